fetch_line_reader: RTL
======================

FETCH_LINE_READER -- requirements
Module: fetch_line_reader

Interface
REQ-001 SHALL have parameter XLEN, default 64, address/PC width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width.
REQ-003 SHALL have parameter LINE_INSTR, default 32, instructions per I-cache line (power of two); LINE_BYTES = LINE_INSTR*4.
REQ-004 SHALL have ports:
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- line_valid_i  in  1  I-cache line valid
- line_ready_o  out  1  reader accepts line this cycle
- line_pc_i  in  XLEN  PC carried with the line
- line_i  in  LINE_INSTR*ILEN  line data; slot k at bits [k*ILEN +: ILEN]
- instr_valid_o  out  1  instruction valid to decode
- instr_ready_i  in  1  decode accepts instruction
- instr_o  out  ILEN  selected instruction
- instr_pc_o  out  XLEN  PC of instr_o
- flush_i  in  1  discard all state
- redirect_i  in  1  control-flow redirect
- redirect_pc_i  in  XLEN  redirect target
- fetch_pc_o  out  XLEN  next PC to request from the I-cache

Function
REQ-005 SHALL implement states IDLE (no line held) and STREAM (line held, instruction valid).
REQ-006 SHALL hold registers: line_q, base_q (line-aligned PC), idx_q (log2(LINE_INSTR) bits), fetch_pc_q.
REQ-007 SHALL drive line_ready_o = !flush_i && !redirect_i && (IDLE || (STREAM && instr_ready_i && idx_q==LINE_INSTR-1)), combinationally.
REQ-008 SHALL, on line_valid_i && line_ready_o: load line_q, set base_q = line_pc_i with low log2(LINE_BYTES) bits cleared, set idx_q = line_pc_i[log2(LINE_BYTES)-1:2], set fetch_pc_q = base_q_new + LINE_BYTES (modulo 2^XLEN), enter STREAM.
REQ-009 SHALL ignore line_pc_i[1:0].
REQ-010 SHALL drive instr_valid_o = (state==STREAM), instr_o = line_q slot idx_q, and instr_pc_o = base_q + idx_q*4.
REQ-011 SHALL, in STREAM with instr_ready_i and idx_q<LINE_INSTR-1, increment idx_q and stay in STREAM.
REQ-012 SHALL, in STREAM with instr_ready_i and idx_q==LINE_INSTR-1, load a line accepted the same cycle per REQ-008 without a bubble; otherwise go to IDLE.
REQ-013 SHALL hold instr_o, instr_pc_o and instr_valid_o stable while instr_valid_o && !instr_ready_i, absent flush/redirect.
REQ-014 SHALL, on flush_i (highest priority), go to IDLE next cycle and discard any line offered that cycle; fetch_pc_q is unchanged.
REQ-015 SHALL, on redirect_i without flush_i in STREAM with redirect_pc_i line base == base_q, set idx_q = redirect_pc_i slot index and stay in STREAM, reusing the line with no I-cache request.
REQ-016 SHALL, on redirect_i without flush_i otherwise (IDLE, or a different line), go to IDLE and set fetch_pc_q = redirect_pc_i with bits [1:0] cleared.
REQ-017 SHALL give redirect_i priority over instruction advance in the same cycle; the instruction presented that cycle is not counted as consumed.
REQ-018 SHALL drive fetch_pc_o = fetch_pc_q.

Reset
REQ-019 SHALL, while rst_i is high at a clock edge, set state IDLE, idx_q 0, base_q 0, fetch_pc_q 0 (boot PC), line_q 0.
REQ-020 SHALL drive line_ready_o = 0 and instr_valid_o = 0 while rst_i is high.
REQ-021 SHALL let a reset mid-STREAM abandon the line; the first cycle after deassertion is IDLE with fetch_pc_o = 0.

Verification
REQ-022 Reset, line pc 0x100, instr_ready_i=1 -> 32 instructions with pc 0x100..0x17C on consecutive cycles; fetch_pc_o=0x180 from cycle after accept; line_ready_o=1 in the 0x17C cycle.
REQ-023 Line pc 0x178 -> only 0x178, 0x17C emitted, then instr_valid_o=0; back-to-back line 0x180 offered during the 0x17C cycle -> 0x180 next cycle, no bubble.
REQ-024 instr_ready_i low 3 cycles at pc 0x108 -> instr_o/instr_pc_o held at 0x108, idx unchanged, line_ready_o=0.
REQ-025 Streaming line 0x100 at pc 0x114, redirect to 0x110 -> next instr_pc_o=0x110, line_ready_o=0; redirect to 0x400 -> IDLE next cycle, fetch_pc_o=0x400.
REQ-026 flush_i with line_valid_i in the same cycle -> line dropped, instr_valid_o=0 next cycle, fetch_pc_o unchanged.
REQ-027 Line pc 0xFFFF_FFFF_FFFF_FF80 -> fetch_pc_o=0; last instr_pc_o=0xFFFF_FFFF_FFFF_FFFC.

Source files
------------

// File: rtl/fetch_line_reader.sv
// fetch_line_reader: holds one I-cache line and streams its instructions to decode,
// handling back-to-back lines, in-line redirects, flushes and the next fetch PC.
module fetch_line_reader #(
    parameter int XLEN       = 64,
    parameter int ILEN       = 32,
    parameter int LINE_INSTR = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       line_valid_i,
    output logic                       line_ready_o,
    input  logic [XLEN-1:0]            line_pc_i,
    input  logic [LINE_INSTR*ILEN-1:0] line_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [ILEN-1:0]            instr_o,
    output logic [XLEN-1:0]            instr_pc_o,
    input  logic                       flush_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic [XLEN-1:0]            fetch_pc_o
);
    localparam int IDX_W = $clog2(LINE_INSTR);
    localparam int OFF_W = IDX_W + 2;
    localparam int LINE_BYTES = LINE_INSTR * 4;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_INSTR - 1);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                           state_q, state_d;
    logic [LINE_INSTR-1:0][ILEN-1:0]  line_q, line_d;
    logic [XLEN-1:0]                  base_q, base_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [XLEN-1:0]                  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]                  new_base;
    logic                             unused_pc_lsb;

    assign unused_pc_lsb = ^{line_pc_i[1:0], redirect_pc_i[1:0]};
    assign new_base      = {line_pc_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    assign line_ready_o  = !rst_i && !flush_i && !redirect_i &&
                           (state_q == IDLE || (instr_ready_i && idx_q == LAST));
    assign instr_valid_o = !rst_i && state_q == STREAM;
    assign instr_o       = line_q[idx_q];
    assign instr_pc_o    = base_q + XLEN'({idx_q, 2'b00});
    assign fetch_pc_o    = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        base_d     = base_q;
        idx_d      = idx_q;
        fetch_pc_d = fetch_pc_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (redirect_i) begin
            // a target inside the held line is served without another I-cache request
            if (state_q == STREAM && redirect_pc_i[XLEN-1:OFF_W] == base_q[XLEN-1:OFF_W]) begin
                idx_d = redirect_pc_i[OFF_W-1:2];
            end else begin
                state_d    = IDLE;
                fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            end
        end else if (line_valid_i && line_ready_o) begin
            state_d    = STREAM;
            line_d     = line_i;
            base_d     = new_base;
            idx_d      = line_pc_i[OFF_W-1:2];
            fetch_pc_d = new_base + XLEN'(LINE_BYTES);
        end else if (state_q == STREAM && instr_ready_i) begin
            state_d = (idx_q == LAST) ? IDLE : STREAM;
            idx_d   = (idx_q == LAST) ? idx_q : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            line_q     <= '0;
            base_q     <= '0;
            idx_q      <= '0;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end
endmodule
